// File: rtl/cordic_arbiter_if.sv
// Requester-side bundle of the cordic arbiter: per-requester valid/ready
// request lanes plus the shared one-hot response strobe and result words.
interface cordic_arbiter_if #(
    parameter int WL    = 16,
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*WL-1:0] req_angle;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ-1:0]    rsp_valid;
    logic [WL-1:0]       rsp_cos;
    logic [WL-1:0]       rsp_sin;
    logic                rsp_error;

    modport master (
        output req_valid, req_angle,
        input  req_ready, rsp_valid, rsp_cos, rsp_sin, rsp_error
    );

    modport slave (
        input  req_valid, req_angle,
        output req_ready, rsp_valid, rsp_cos, rsp_sin, rsp_error
    );
endinterface

// File: rtl/cordic_arbiter.sv
// Round-robin front end sharing one cordic core among N_REQ requesters,
// with signed range check, start pulse and done watchdog.
module cordic_arbiter #(
    parameter int WL        = 16,
    parameter int N_REQ     = 4,
    parameter int ANGLE_MAX = 25736,
    parameter int TIMEOUT   = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    cordic_arbiter_if.slave bus,
    output logic          busy,
    output logic          cordic_start,
    output logic [WL-1:0] cordic_angle,
    input  logic [WL-1:0] cordic_cos,
    input  logic [WL-1:0] cordic_sin,
    input  logic          cordic_done
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic signed [WL:0] AMAX = (WL+1)'(ANGLE_MAX);
    localparam logic signed [WL:0] AMIN = -AMAX;
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state, state_d;
    logic [IW-1:0]     last, last_d;
    logic [IW-1:0]     gnt, gnt_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic              busy_d, start_d;
    logic [WL-1:0]     angle_d;
    logic [N_REQ-1:0]  rv, rv_d;
    logic [WL-1:0]     cos_q, cos_d, sin_q, sin_d;
    logic              err_q, err_d;

    logic [IW-1:0]     pick;
    logic              found;
    logic [WL-1:0]     angle_sel;
    logic signed [WL:0] ext;
    logic              in_range;

    // First valid requester after the last one served, with wrap-around.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!found && bus.req_valid[(int'(last) + k) % N_REQ]) begin
                found = 1'b1;
                pick  = IW'((int'(last) + k) % N_REQ);
            end
        end
    end

    assign angle_sel = bus.req_angle[int'(pick)*WL +: WL];
    // One extra bit so the most negative code cannot overflow the check.
    assign ext       = {angle_sel[WL-1], angle_sel};
    assign in_range  = (ext <= AMAX) && (ext >= AMIN);

    assign bus.req_ready = (rst_n && state == IDLE && found)
                         ? (ONE << pick) : '0;

    always_comb begin
        state_d = state;
        last_d  = last;
        gnt_d   = gnt;
        cnt_d   = cnt;
        start_d = 1'b0;
        angle_d = cordic_angle;
        rv_d    = '0;
        cos_d   = cos_q;
        sin_d   = sin_q;
        err_d   = err_q;
        unique case (state)
            IDLE: begin
                if (found) begin
                    gnt_d = pick;
                    if (in_range) begin
                        state_d = ISSUE;
                        start_d = 1'b1;
                        angle_d = angle_sel;
                    end else begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        cos_d   = '0;
                        sin_d   = '0;
                        rv_d    = ONE << pick;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt + 1'b1;
                // A done still high from the previous job is ignored at cnt 0.
                if (cnt != '0 && cordic_done) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    cos_d   = cordic_cos;
                    sin_d   = cordic_sin;
                    rv_d    = ONE << gnt;
                end else if (cnt == CW'(TIMEOUT - 2)) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    cos_d   = '0;
                    sin_d   = '0;
                    rv_d    = ONE << gnt;
                end
            end
            RESP: begin
                last_d  = gnt;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            last         <= IW'(N_REQ - 1);
            gnt          <= '0;
            cnt          <= '0;
            busy         <= 1'b0;
            cordic_start <= 1'b0;
            cordic_angle <= '0;
            rv           <= '0;
            cos_q        <= '0;
            sin_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state        <= state_d;
            last         <= last_d;
            gnt          <= gnt_d;
            cnt          <= cnt_d;
            busy         <= busy_d;
            cordic_start <= start_d;
            cordic_angle <= angle_d;
            rv           <= rv_d;
            cos_q        <= cos_d;
            sin_q        <= sin_d;
            err_q        <= err_d;
        end
    end

    assign bus.rsp_valid = rv;
    assign bus.rsp_cos   = cos_q;
    assign bus.rsp_sin   = sin_q;
    assign bus.rsp_error = err_q;
endmodule

// File: tb/tb_cordic_arbiter.sv
// Scoreboard bench for cordic_arbiter driving a stub core with programmable
// latency (cos = angle, sin = -angle).
module tb_cordic_arbiter;
    localparam int WL = 16;
    localparam int N  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, cordic_start, cordic_done;
    logic [WL-1:0] cordic_angle, cordic_cos, cordic_sin;

    cordic_arbiter_if #(.WL(WL), .N_REQ(N)) bus ();

    cordic_arbiter dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy),
        .cordic_start(cordic_start), .cordic_angle(cordic_angle),
        .cordic_cos(cordic_cos), .cordic_sin(cordic_sin),
        .cordic_done(cordic_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int start_cnt = 0;
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (cordic_start) start_cnt = start_cnt + 1;
    end

    // Stub core
    int lat = 2;
    bit suppress = 1'b0;
    int scnt = 0;
    logic [WL-1:0] sa = '0;
    logic sdone = 1'b0;
    always @(posedge clk) begin
        if (cordic_start) begin
            sa    <= cordic_angle;
            scnt  <= lat - 1;
            sdone <= (lat == 1) && !suppress;
        end else if (scnt > 0) begin
            scnt <= scnt - 1;
            if (scnt == 1 && !suppress) sdone <= 1'b1;
        end
    end
    assign cordic_done = sdone;
    assign cordic_cos  = sa;
    assign cordic_sin  = -sa;

    typedef struct {
        int g;
        logic [WL-1:0] c;
        logic [WL-1:0] s;
        logic e;
        int t;
    } exp_t;
    exp_t q[$];

    int tests = 0;
    int fails = 0;
    int rsp_cnt [N];

    task automatic chk(string name, longint act, longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per response strobe.
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid != '0) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rsp: rsp_valid=%b at cycle %0d",
                         bus.rsp_valid, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rsp_valid", longint'(bus.rsp_valid), longint'(1 << e.g));
                chk("rsp_cycle", cyc, e.t);
                chk("rsp_cos", longint'(bus.rsp_cos), longint'(e.c));
                chk("rsp_sin", longint'(bus.rsp_sin), longint'(e.s));
                chk("rsp_error", longint'(bus.rsp_error), longint'(e.e));
                rsp_cnt[e.g]++;
            end
        end
    end

    function automatic int one_hot_idx(logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic set_angle(int i, logic [WL-1:0] a);
        bus.req_angle[i*WL +: WL] = a;
    endtask

    // Waits (bounded) for any req_ready; returns granted index and cycle.
    task automatic wait_grant(output int g, output int t);
        g = -1;
        t = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (bus.req_ready != '0) begin
                g = one_hot_idx(bus.req_ready);
                t = cyc;
                chk("ready_onehot", longint'($onehot(bus.req_ready)), 1);
                return;
            end
        end
        tests++;
        fails++;
        $display("FAIL grant_timeout: no req_ready within 300 cycles");
    endtask

    task automatic wait_empty();
        for (int n = 0; n < 300; n++) begin
            if (q.size() == 0) return;
            @(negedge clk);
        end
        tests++;
        fails++;
        $display("FAIL rsp_timeout: %0d responses outstanding", q.size());
        q.delete();
    endtask

    // kind: 0 normal, 1 out of range, 2 watchdog expiry
    task automatic single(int i, logic [WL-1:0] a, int l, int kind);
        int g, t, sc;
        exp_t e;
        @(posedge clk);
        #1;
        lat = l;
        set_angle(i, a);
        bus.req_valid[i] = 1'b1;
        sc = start_cnt;
        wait_grant(g, t);
        chk("grant", g, i);
        e.g = i;
        e.c = (kind == 0) ? a : '0;
        e.s = (kind == 0) ? -a : '0;
        e.e = (kind != 0);
        e.t = (kind == 1) ? t + 1 :
              (kind == 2) ? t + 65 :
              t + 2 + ((l > 2) ? l : 2);
        q.push_back(e);
        @(posedge clk);
        #1;
        bus.req_valid[i] = 1'b0;
        @(negedge clk);
        chk("start_pulse", longint'(cordic_start), (kind != 1) ? 1 : 0);
        if (kind != 1) chk("start_angle", longint'(cordic_angle), longint'(a));
        wait_empty();
        if (kind == 1) chk("no_start", start_cnt, sc);
    endtask

    initial begin
        int g, t;
        exp_t e;
        bus.req_valid = '0;
        bus.req_angle = '0;
        for (int i = 0; i < N; i++) rsp_cnt[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_start", longint'(cordic_start), 0);
        chk("rst_angle", longint'(cordic_angle), 0);
        chk("rst_rsp_valid", longint'(bus.rsp_valid), 0);
        chk("rst_error", longint'(bus.rsp_error), 0);
        chk("rst_ready", longint'(bus.req_ready), 0);

        single(0, 16'd12868, 15, 0);
        single(3, -16'sd5000, 2, 0);

        // Round robin with all four requesters held valid
        @(posedge clk);
        #1;
        lat = 2;
        for (int i = 0; i < N; i++) begin
            set_angle(i, 16'(100 * (i + 1)));
            rsp_cnt[i] = 0;
        end
        bus.req_valid = '1;
        for (int op = 0; op < 8; op++) begin
            wait_grant(g, t);
            chk("rr_grant", g, op % N);
            if (g < 0) break;
            e.g = g;
            e.c = 16'(100 * (g + 1));
            e.s = -e.c;
            e.e = 1'b0;
            e.t = t + 4;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        wait_empty();
        for (int i = 0; i < N; i++) chk("rr_count", rsp_cnt[i], 2);

        // Range boundaries
        single(1, 16'd25736, 3, 0);
        single(2, -16'sd25736, 3, 0);
        single(0, 16'd25737, 3, 1);
        single(0, 16'h8000, 3, 1);

        // Watchdog, then normal recovery
        suppress = 1'b1;
        single(0, 16'd1000, 5, 2);
        suppress = 1'b0;
        single(0, 16'd2000, 3, 0);

        // done still high from previous job, L = 1
        single(0, 16'd3000, 1, 0);

        // Reset during WAIT
        @(posedge clk);
        #1;
        lat = 15;
        set_angle(2, 16'd7000);
        bus.req_valid[2] = 1'b1;
        wait_grant(g, t);
        chk("rst_test_grant", g, 2);
        @(posedge clk);
        #1;
        bus.req_valid[2] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", longint'(busy), 0);
        chk("mid_rst_start", longint'(cordic_start), 0);
        chk("mid_rst_angle", longint'(cordic_angle), 0);
        chk("mid_rst_rsp_valid", longint'(bus.rsp_valid), 0);
        chk("mid_rst_error", longint'(bus.rsp_error), 0);
        chk("mid_rst_cos", longint'(bus.rsp_cos), 0);
        repeat (25) @(posedge clk);
        #1;
        lat = 2;
        for (int i = 0; i < N; i++) set_angle(i, 16'(50 + i));
        bus.req_valid = '1;
        wait_grant(g, t);
        chk("post_rst_grant", g, 0);
        e.g = 0;
        e.c = 16'd50;
        e.s = -16'sd50;
        e.e = 1'b0;
        e.t = t + 4;
        q.push_back(e);
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        wait_empty();
        repeat (5) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
